// File: rtl/rip_axi_slave_ram_if.sv
// AXI bus bundle shared by the CPU master and the RAM responder.
interface rip_axi_interface #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/rip_axi_slave_ram.sv
// Word-addressed AXI RAM responder: one write burst and one read burst in flight,
// independent channels, RAM split into byte-lane banks.
module rip_axi_slave_ram_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  // same-edge read of a word being written returns the old byte
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module rip_axi_slave_ram #(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic             clk,
  input logic             rst,
  rip_axi_interface.slave axi
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int LSB       = $clog2(NUM_LANES);
  localparam int IW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(NUM_LANES);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [1:0]            burst;
  } req_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  // borrow bit of the subtraction flags addresses below BASE_ADDR
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, BASE_ADDR};
    return !d[ADDR_WIDTH] && ((d[ADDR_WIDTH-1:0] >> LSB) < ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IW'((a - BASE_ADDR) >> LSB);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input req_t r);
    return (r.burst == 2'b01) ? r.addr + STEP : r.addr;
  endfunction

  wstate_t ws;
  rstate_t rs;
  req_t    wr, rd;
  logic [7:0] wbeat, rbeat;
  logic    werr, rok;
  logic [NUM_LANES-1:0][7:0] rq;

  assign axi.awready = !rst && (ws == W_IDLE);
  assign axi.wready  = !rst && (ws == W_DATA);
  assign axi.arready = !rst && (rs == R_IDLE);

  logic w_fire, w_ok, w_last, werr_nxt, r_ok;
  assign w_fire   = axi.wvalid && axi.wready;
  assign w_ok     = !wr.burst[1] && in_range(wr.addr);
  assign w_last   = (wbeat == wr.len);
  assign werr_nxt = werr || !w_ok || (axi.wlast != w_last);
  assign r_ok     = !rd.burst[1] && in_range(rd.addr);

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      rip_axi_slave_ram_lane #(.DEPTH(MEM_DEPTH), .AW(IW)) u_lane (
        .clk   (clk),
        .we    (w_fire && w_ok && axi.wstrb[i]),
        .waddr (word_idx(wr.addr)),
        .wdata (axi.wdata[8*i +: 8]),
        .re    (rs == R_FETCH),
        .raddr (word_idx(rd.addr)),
        .rdata (rq[i])
      );
    end
  endgenerate

  assign axi.rdata = (rs == R_DATA && rok) ? rq : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws         <= W_IDLE;
      wr         <= '0;
      wbeat      <= '0;
      werr       <= 1'b0;
      axi.bvalid <= 1'b0;
      axi.bid    <= '0;
      axi.bresp  <= '0;
    end else begin
      case (ws)
        W_IDLE: if (axi.awvalid) begin
          wr    <= '{id: axi.awid, addr: axi.awaddr, len: axi.awlen, burst: axi.awburst};
          wbeat <= '0;
          werr  <= axi.awburst[1];
          ws    <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          werr    <= werr_nxt;
          wr.addr <= next_addr(wr);
          wbeat   <= wbeat + 8'd1;
          if (w_last) begin
            ws         <= W_RESP;
            axi.bvalid <= 1'b1;
            axi.bid    <= wr.id;
            axi.bresp  <= {1'b0, werr_nxt};
          end
        end
        W_RESP: if (axi.bready) begin
          axi.bvalid <= 1'b0;
          ws         <= W_IDLE;
        end
        default: ws <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs         <= R_IDLE;
      rd         <= '0;
      rbeat      <= '0;
      rok        <= 1'b0;
      axi.rvalid <= 1'b0;
      axi.rid    <= '0;
      axi.rresp  <= '0;
      axi.rlast  <= 1'b0;
    end else begin
      case (rs)
        R_IDLE: if (axi.arvalid) begin
          rd    <= '{id: axi.arid, addr: axi.araddr, len: axi.arlen, burst: axi.arburst};
          rbeat <= '0;
          rs    <= R_FETCH;
        end
        R_FETCH: begin
          rok        <= r_ok;
          axi.rvalid <= 1'b1;
          axi.rid    <= rd.id;
          axi.rresp  <= {1'b0, !r_ok};
          axi.rlast  <= (rbeat == rd.len);
          rs         <= R_DATA;
        end
        R_DATA: if (axi.rready) begin
          axi.rvalid <= 1'b0;
          axi.rlast  <= 1'b0;
          if (rbeat == rd.len) begin
            rs <= R_IDLE;
          end else begin
            rd.addr <= next_addr(rd);
            rbeat   <= rbeat + 8'd1;
            rs      <= R_FETCH;
          end
        end
        default: rs <= R_IDLE;
      endcase
    end
  end

  // size/lock/cache/prot/WID carry no meaning here; every beat is full width
  logic unused_ign;
  assign unused_ign = ^{axi.wid, axi.awsize, axi.awlock, axi.awcache, axi.awprot,
                        axi.arsize, axi.arlock, axi.arcache, axi.arprot};
endmodule

// File: tb/tb_rip_axi_slave_ram.sv
// Bench for rip_axi_slave_ram: burst table with expected-response scoreboard,
// plus hand sequences for backpressure, shared-cycle handshakes and reset.
module tb_rip_axi_slave_ram;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rip_axi_interface #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  rip_axi_slave_ram #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                      .MEM_DEPTH(1024), .BASE_ADDR(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .axi (axi)
  );

  typedef struct {
    bit              wr;
    logic [3:0]      id;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [1:0]      burst;
    logic [3:0][31:0] data;   // write data, or expected read data
    logic [3:0][3:0] strb;
    logic [3:0]      wl;      // WLAST per beat
    logic [3:0]      rerr;    // expected RRESP bit per beat
    logic [1:0]      bresp;
    int              stall_beat;
    int              stall;   // cycles of RREADY/BREADY held low
  } vec_t;

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  vec_t  tv[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  function automatic vec_t W(logic [3:0] id, logic [31:0] a, logic [7:0] len, logic [1:0] bu,
                             logic [3:0][31:0] d, logic [3:0][3:0] s, logic [1:0] resp);
    vec_t v;
    v = '{wr: 1'b1, id: id, addr: a, len: len, burst: bu, data: d, strb: s,
          wl: 4'(1 << len), rerr: '0, bresp: resp, stall_beat: -1, stall: 0};
    return v;
  endfunction

  function automatic vec_t R(logic [3:0] id, logic [31:0] a, logic [7:0] len, logic [1:0] bu,
                             logic [3:0][31:0] d, logic [3:0] rerr);
    vec_t v;
    v = '{wr: 1'b0, id: id, addr: a, len: len, burst: bu, data: d, strb: '0,
          wl: '0, rerr: rerr, bresp: '0, stall_beat: -1, stall: 0};
    return v;
  endfunction

  // ch: 0=AW 1=W 2=AR; valid must already be driven
  task automatic handshake(input int ch, output bit ok);
    int n = 0;
    bit hs;
    do begin
      @(negedge clk);
      hs = (ch == 0) ? axi.awready : (ch == 1) ? axi.wready : axi.arready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < TMO);
    ok = hs;
  endtask

  task automatic do_write(input vec_t v);
    bit ok;
    int n;
    bexp_t e;
    bq.push_back('{id: v.id, resp: v.bresp});
    axi.awid = v.id; axi.awaddr = v.addr; axi.awlen = v.len; axi.awburst = v.burst;
    axi.awvalid = 1'b1;
    handshake(0, ok);
    axi.awvalid = 1'b0;
    chk("aw_hs", 64'(ok), 64'd1);
    for (int b = 0; b <= int'(v.len); b++) begin
      axi.wdata = v.data[b]; axi.wstrb = v.strb[b]; axi.wlast = v.wl[b];
      axi.wvalid = 1'b1;
      handshake(1, ok);
      if (!ok) chk("w_hs", 64'(ok), 64'd1);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.bvalid && n < TMO);
    chk("b_lat", 64'(n), 64'd1);
    e = bq.pop_front();
    for (int k = 0; k < v.stall; k++) begin
      chk("b_stall", {axi.bvalid, axi.bid, axi.bresp, axi.awready}, {1'b1, e.id, e.resp, 1'b0});
      @(negedge clk);
    end
    chk("b_resp", {axi.bvalid, axi.bid, axi.bresp}, {1'b1, e.id, e.resp});
    axi.bready = 1'b1;
    @(posedge clk); #1;
    axi.bready = 1'b0;
  endtask

  task automatic do_read(input vec_t v);
    bit ok;
    int n;
    rexp_t e;
    for (int b = 0; b <= int'(v.len); b++)
      rq.push_back('{id: v.id, data: v.data[b], resp: {1'b0, v.rerr[b]}, last: (b == int'(v.len))});
    axi.arid = v.id; axi.araddr = v.addr; axi.arlen = v.len; axi.arburst = v.burst;
    axi.arvalid = 1'b1;
    handshake(2, ok);
    axi.arvalid = 1'b0;
    chk("ar_hs", 64'(ok), 64'd1);
    for (int b = 0; b <= int'(v.len); b++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.rvalid && n < TMO);
      if (b == 0) chk("r_lat", 64'(n), 64'd2);
      e = rq.pop_front();
      if (b == v.stall_beat)
        for (int k = 0; k < v.stall; k++) begin
          chk("r_stall", {axi.rvalid, axi.rdata, axi.rlast}, {1'b1, e.data, e.last});
          @(negedge clk);
        end
      chk("r_data", 64'(axi.rdata), 64'(e.data));
      chk("r_ctl", {axi.rvalid, axi.rid, axi.rresp, axi.rlast}, {1'b1, e.id, e.resp, e.last});
      axi.rready = 1'b1;
      @(posedge clk); #1;
      axi.rready = 1'b0;
    end
  endtask

  initial begin
    vec_t v;
    int stale;
    {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache,
     axi.awprot, axi.awvalid} = '0;
    {axi.wid, axi.wdata, axi.wstrb, axi.wlast, axi.wvalid, axi.bready} = '0;
    {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache,
     axi.arprot, axi.arvalid, axi.rready} = '0;

    tv.push_back(W(4'h3, 32'h10, 8'd0, 2'b01, {96'h0, 32'hDEADBEEF}, 16'hFFFF, 2'd0));
    tv.push_back(R(4'h5, 32'h10, 8'd0, 2'b01, {96'h0, 32'hDEADBEEF}, 4'b0000));
    tv.push_back(W(4'h0, 32'h28, 8'd0, 2'b01, 128'h0, 16'hFFFF, 2'd0));
    tv.push_back(W(4'h1, 32'h20, 8'd3, 2'b01, {32'd4, 32'hAAAA5555, 32'd2, 32'd1},
                   {4'hF, 4'h3, 4'hF, 4'hF}, 2'd0));
    v = R(4'h2, 32'h20, 8'd3, 2'b01, {32'd4, 32'h00005555, 32'd2, 32'd1}, 4'b0000);
    v.stall_beat = 1; v.stall = 4;
    tv.push_back(v);
    tv.push_back(W(4'h4, 32'h40, 8'd2, 2'b00, {32'd0, 32'd9, 32'd8, 32'd7}, 16'hFFFF, 2'd0));
    tv.push_back(R(4'h6, 32'h40, 8'd0, 2'b01, {96'h0, 32'd9}, 4'b0000));
    tv.push_back(R(4'h7, 32'h40, 8'd2, 2'b10, 128'h0, 4'b0111));
    tv.push_back(W(4'h9, 32'h0, 8'd0, 2'b01, {96'h0, 32'hCAFEF00D}, 16'hFFFF, 2'd0));
    tv.push_back(W(4'h8, 32'h1000, 8'd0, 2'b01, {96'h0, 32'h12345678}, 16'hFFFF, 2'd1));
    tv.push_back(R(4'h1, 32'h0, 8'd0, 2'b01, {96'h0, 32'hCAFEF00D}, 4'b0000));
    tv.push_back(W(4'hA, 32'hFFC, 8'd0, 2'b01, {96'h0, 32'h0BADC0DE}, 16'hFFFF, 2'd0));
    tv.push_back(R(4'hB, 32'hFFC, 8'd1, 2'b01, {64'h0, 32'h0, 32'h0BADC0DE}, 4'b0010));
    tv.push_back(W(4'hC, 32'h10, 8'd0, 2'b10, {96'h0, 32'h11111111}, 16'hFFFF, 2'd1));
    tv.push_back(R(4'hD, 32'h10, 8'd0, 2'b01, {96'h0, 32'hDEADBEEF}, 4'b0000));
    v = W(4'hE, 32'h50, 8'd2, 2'b01, {32'd0, 32'h33, 32'h22, 32'h11}, 16'hFFFF, 2'd1);
    v.wl = 4'b0001; v.stall = 5;
    tv.push_back(v);
    tv.push_back(R(4'hF, 32'h50, 8'd2, 2'b01, {32'd0, 32'h33, 32'h22, 32'h11}, 4'b0000));
    tv.push_back(W(4'h2, 32'h60, 8'd1, 2'b11, {64'h0, 32'h5, 32'h6}, 16'hFFFF, 2'd1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {axi.awready, axi.wready, axi.bvalid, axi.bid, axi.bresp, axi.arready,
                        axi.rid, axi.rdata, axi.rresp, axi.rlast, axi.rvalid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {axi.awready, axi.arready, axi.wready}, 3'b110);
    @(posedge clk); #1;

    foreach (tv[i]) begin
      if (tv[i].wr) do_write(tv[i]);
      else          do_read(tv[i]);
    end

    // AW and AR on the same cycle, then reset lands mid-burst on both
    axi.awid = 4'h3; axi.awaddr = 32'h100; axi.awlen = 8'd3; axi.awburst = 2'b01;
    axi.arid = 4'h9; axi.araddr = 32'h20;  axi.arlen = 8'd3; axi.arburst = 2'b01;
    axi.awvalid = 1'b1; axi.arvalid = 1'b1;
    @(negedge clk);
    chk("aw_ar_same", {axi.awready, axi.arready}, 2'b11);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    axi.wvalid = 1'b1; axi.wdata = 32'h5; axi.wstrb = 4'hF; axi.wlast = 1'b0;
    @(posedge clk); #1;
    axi.wdata = 32'h6; axi.rready = 1'b1;
    @(negedge clk);
    chk("rst_pre_r", {axi.rvalid, axi.rdata}, {1'b1, 32'd1});
    @(posedge clk); #1;
    axi.rready = 1'b0; axi.wdata = 32'h7;
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async", {axi.awready, axi.wready, axi.bvalid, axi.bid, axi.bresp, axi.arready,
                      axi.rid, axi.rdata, axi.rresp, axi.rlast, axi.rvalid}, 64'd0);
    axi.wvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    axi.bready = 1'b1; axi.rready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (axi.bvalid || axi.rvalid) stale++;
    end
    chk("no_stale", 64'(stale), 64'd0);
    chk("rdy_after_rst", {axi.awready, axi.arready}, 2'b11);
    axi.bready = 1'b0; axi.rready = 1'b0;
    @(posedge clk); #1;
    do_read(R(4'h4, 32'h20, 8'd3, 2'b01, {32'd4, 32'h00005555, 32'd2, 32'd1}, 4'b0000));
    do_read(R(4'h6, 32'h10, 8'd0, 2'b01, {96'h0, 32'hDEADBEEF}, 4'b0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
